// File: rtl/piano_pkg.sv
// Shared types and constants for the piano voice scheduler: note indices,
// octave limits, the base half-period table and the sample sequencer states.
package piano_pkg;

  localparam int         NOTE_COUNT = 12;
  localparam logic [1:0] OCT_MAX    = 2'd3;
  localparam int         HALF_W     = 18;

  typedef logic [3:0]        note_t;
  typedef logic [HALF_W-1:0] half_t;

  typedef enum logic [0:0] {
    SEQ_IDLE = 1'b0,
    SEQ_PEND = 1'b1
  } seq_state_t;

  // Half period in CLOCK_50 cycles of each note at octave shift 0.
  function automatic half_t base_half(input note_t note);
    half_t r;
    case (note)
      4'd0:    r = 18'd191109;
      4'd1:    r = 18'd180388;
      4'd2:    r = 18'd170265;
      4'd3:    r = 18'd160705;
      4'd4:    r = 18'd151685;
      4'd5:    r = 18'd143172;
      4'd6:    r = 18'd135139;
      4'd7:    r = 18'd127551;
      4'd8:    r = 18'd120395;
      4'd9:    r = 18'd113636;
      4'd10:   r = 18'd107259;
      4'd11:   r = 18'd101239;
      default: r = 18'd191109;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/voice_scheduler_if.sv
// Audio_Controller output FIFO handshake: the scheduler writes one mixed
// sample per strobe whenever the controller reports free space.
interface voice_scheduler_if;
  logic               audio_out_allowed;
  logic               write_audio_out;
  logic signed [31:0] sample_out;

  modport master (
    input  audio_out_allowed,
    output write_audio_out,
    output sample_out
  );

  modport slave (
    output audio_out_allowed,
    input  write_audio_out,
    input  sample_out
  );
endinterface

// File: rtl/voice_scheduler_tone_voice.sv
// One square-wave tone voice: toggles its phase every i_half cycles while
// active and contributes +/-AMPLITUDE to the mix, or 0 when free.
module tone_voice
  import piano_pkg::*;
#(
  parameter logic signed [31:0] AMPLITUDE = 32'sd100000000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_clear,
  input  half_t              i_half,
  output logic               o_active,
  output logic signed [31:0] o_contrib
);

  logic  r_active;
  logic  r_phase;
  half_t r_count;
  half_t w_last;

  // A counter already past a freshly shortened half period toggles at once.
  assign w_last = i_half - 18'd1;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_active <= 1'b0;
      r_count  <= 18'd0;
      r_phase  <= 1'b1;
    end else if (i_load) begin
      r_active <= 1'b1;
      r_count  <= 18'd0;
      r_phase  <= 1'b1;
    end else if (i_clear) begin
      r_active <= 1'b0;
      r_count  <= 18'd0;
      r_phase  <= 1'b1;
    end else if (r_active) begin
      if (r_count >= w_last) begin
        r_count <= 18'd0;
        r_phase <= ~r_phase;
      end else begin
        r_count <= r_count + 18'd1;
      end
    end
  end

  always_comb begin
    o_contrib = 32'sd0;
    if (!r_active) begin
      o_contrib = 32'sd0;
    end else if (r_phase) begin
      o_contrib = AMPLITUDE;
    end else begin
      o_contrib = -AMPLITUDE;
    end
  end

  assign o_active = r_active;

endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic voice allocator, saturating octave shift and fixed-rate sample
// sequencer feeding the Audio_Controller output FIFO.
module voice_scheduler
  import piano_pkg::*;
#(
  parameter int                 NUM_VOICES = 4,
  parameter logic signed [31:0] AMPLITUDE  = 32'sd100000000,
  parameter int                 SAMPLE_DIV = 1042
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [11:0]           key_req,
  input  logic                  oct_up,
  input  logic                  oct_down,
  voice_scheduler_if.master     aud,
  output logic [NUM_VOICES-1:0] voice_busy,
  output logic [1:0]            octave,
  output logic                  key_overflow,
  output logic                  sample_drop
);

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

  logic [3:0]            r_scan;
  note_t                 r_note [NUM_VOICES];
  logic                  r_ovf;
  logic [NUM_VOICES-1:0] w_busy, w_load, w_clear;
  logic                  w_key, w_assigned, w_free, w_overflow;
  logic [VW-1:0]         w_assigned_idx, w_free_idx;

  // The scanned key either claims the lowest free voice or releases its own.
  always_comb begin
    w_key          = key_req[r_scan];
    w_assigned     = 1'b0;
    w_assigned_idx = '0;
    w_free         = 1'b0;
    w_free_idx     = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      w_assigned     = w_assigned | (w_busy[v] & (r_note[v] == r_scan));
      w_assigned_idx = (w_busy[v] && (r_note[v] == r_scan)) ? VW'(v) : w_assigned_idx;
      w_free         = w_free | ~w_busy[v];
      w_free_idx     = w_busy[v] ? w_free_idx : VW'(v);
    end
    w_overflow = w_key & ~w_assigned & ~w_free;
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_load[v]  = w_key & ~w_assigned & w_free & (w_free_idx == VW'(v));
      w_clear[v] = ~w_key & w_assigned & (w_assigned_idx == VW'(v));
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_scan <= 4'd0;
      r_ovf  <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) r_note[v] <= 4'd0;
    end else begin
      r_scan <= (r_scan == 4'(NOTE_COUNT - 1)) ? 4'd0 : r_scan + 4'd1;
      r_ovf  <= w_overflow;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (w_load[v]) r_note[v] <= r_scan;
      end
    end
  end

  logic [1:0] r_up_sync, r_dn_sync, r_octave;
  logic       r_up_prev, r_dn_prev;
  logic       w_up_edge, w_dn_edge;

  assign w_up_edge = r_up_sync[1] & ~r_up_prev;
  assign w_dn_edge = r_dn_sync[1] & ~r_dn_prev;

  // Opposing edges in the same cycle cancel; both ends saturate.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_up_sync <= 2'b00;
      r_dn_sync <= 2'b00;
      r_up_prev <= 1'b0;
      r_dn_prev <= 1'b0;
      r_octave  <= 2'd0;
    end else begin
      r_up_sync <= {r_up_sync[0], oct_up};
      r_dn_sync <= {r_dn_sync[0], oct_down};
      r_up_prev <= r_up_sync[1];
      r_dn_prev <= r_dn_sync[1];
      if (w_up_edge && !w_dn_edge && (r_octave != OCT_MAX)) begin
        r_octave <= r_octave + 2'd1;
      end else if (w_dn_edge && !w_up_edge && (r_octave != 2'd0)) begin
        r_octave <= r_octave - 2'd1;
      end
    end
  end

  logic signed [31:0] w_contrib [NUM_VOICES];
  half_t              w_half    [NUM_VOICES];
  logic signed [31:0] w_mix;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    assign w_half[g] = base_half(r_note[g]) >> r_octave;
    tone_voice #(.AMPLITUDE(AMPLITUDE)) u_voice (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .i_load    (w_load[g]),
      .i_clear   (w_clear[g]),
      .i_half    (w_half[g]),
      .o_active  (w_busy[g]),
      .o_contrib (w_contrib[g])
    );
  end

  always_comb begin
    w_mix = 32'sd0;
    for (int v = 0; v < NUM_VOICES; v++) w_mix = w_mix + w_contrib[v];
  end

  seq_state_t         r_state, w_state_next;
  logic [DW-1:0]      r_div;
  logic               w_strobe, w_write_next, w_drop_next;
  logic               r_write, r_drop;
  logic signed [31:0] r_sample;

  assign w_strobe = (r_div == DIV_LAST);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_div   <= '0;
      r_state <= SEQ_IDLE;
    end else begin
      r_div   <= w_strobe ? '0 : r_div + DW'(1);
      r_state <= w_state_next;
    end
  end

  // A strobe with space writes straight away; otherwise the sample waits.
  always_comb begin
    w_state_next = r_state;
    w_write_next = 1'b0;
    w_drop_next  = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        if (w_strobe && aud.audio_out_allowed) begin
          w_write_next = 1'b1;
          w_state_next = SEQ_IDLE;
        end else if (w_strobe) begin
          w_state_next = SEQ_PEND;
        end else begin
          w_state_next = SEQ_IDLE;
        end
      end
      SEQ_PEND: begin
        w_drop_next = w_strobe;
        if (aud.audio_out_allowed) begin
          w_write_next = 1'b1;
          w_state_next = SEQ_IDLE;
        end else begin
          w_state_next = SEQ_PEND;
        end
      end
      default: w_state_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_write  <= 1'b0;
      r_drop   <= 1'b0;
      r_sample <= 32'sd0;
    end else begin
      r_write <= w_write_next;
      r_drop  <= w_drop_next;
      if (w_strobe) r_sample <= w_mix;
    end
  end

  assign aud.write_audio_out = r_write;
  assign aud.sample_out      = r_sample;
  assign voice_busy          = w_busy;
  assign octave              = r_octave;
  assign key_overflow        = r_ovf;
  assign sample_drop         = r_drop;

endmodule
